// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor: default parameters,
// the mode constant and the saturating next-value helper that both the
// counter table and the statistics counters rely on.
package branch_predictor_pkg;

  // GHR_BITS of zero selects plain bimodal indexing.
  localparam int unsigned BP_MODE_BIMODAL = 0;

  localparam int unsigned BP_DEF_PC_WIDTH  = 32;
  localparam int unsigned BP_DEF_IDX_BITS  = 6;
  localparam int unsigned BP_DEF_CTR_BITS  = 2;
  localparam int unsigned BP_DEF_GHR_BITS  = BP_MODE_BIMODAL;
  localparam int unsigned BP_DEF_STAT_BITS = 32;

  // Weakly-not-taken value for a w-bit counter: 2^(w-1)-1 (0 for w = 1).
  function automatic logic [31:0] ctr_weak_nt(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Saturating step of a w-bit counter (w <= 32) carried in a 32-bit value.
  // inc and dec together, or neither, hold the value.
  function automatic logic [31:0] sat_next(input logic [31:0] v,
                                           input logic        inc,
                                           input logic        dec,
                                           input int unsigned w);
    logic [31:0] max_v;
    max_v    = 32'hFFFF_FFFF >> (32 - w);
    sat_next = v;
    if (inc && !dec && (v != max_v)) begin
      sat_next = v + 32'd1;
    end else if (dec && !inc && (v != 32'd0)) begin
      sat_next = v - 32'd1;
    end
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Generic saturating up/down counter with enable; clears on synchronous reset.
module sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next value: saturating step when enabled, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = W'(sat_next(32'(cnt_q), inc, dec, W));
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: table of saturating counters indexed in IF
// (bimodal or gshare), trained non-speculatively at branch resolution in EX,
// plus saturating branch / mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = BP_DEF_PC_WIDTH,
  parameter int unsigned IDX_BITS  = BP_DEF_IDX_BITS,
  parameter int unsigned CTR_BITS  = BP_DEF_CTR_BITS,
  parameter int unsigned GHR_BITS  = BP_DEF_GHR_BITS,
  parameter int unsigned STAT_BITS = BP_DEF_STAT_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 pred_taken,
  output logic [IDX_BITS-1:0]  pred_idx,
  input  logic                 update_valid,
  input  logic [IDX_BITS-1:0]  update_idx,
  input  logic                 update_taken,
  input  logic                 update_mispred,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispreds
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  // History register keeps at least one bit so bimodal builds stay legal;
  // in that mode it is tied to zero and never reaches the index.
  localparam int unsigned GW = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_weak_nt(CTR_BITS));

  // Register array rather than RAM: needs reset init and an async read port.
  logic [CTR_BITS-1:0] table_q [ENTRIES];
  logic [CTR_BITS-1:0] table_d [ENTRIES];
  logic [GW-1:0]       ghr_q;
  logic [GW-1:0]       ghr_d;
  logic [IDX_BITS-1:0] base_idx;
  logic                unused_pc;

  // Only PC[IDX_BITS+1:2] selects the entry; the rest is deliberately dropped.
  assign unused_pc = ^lookup_pc;

  // Zero-latency lookup from registered state; no bypass of a same-cycle update.
  always_comb begin
    base_idx   = lookup_pc[IDX_BITS+1:2];
    pred_idx   = base_idx;
    if (GHR_BITS != BP_MODE_BIMODAL) begin
      pred_idx = base_idx ^ IDX_BITS'(ghr_q);
    end
    pred_taken = table_q[pred_idx][CTR_BITS-1];
  end

  // Train the resolved entry with a saturating step toward the outcome.
  always_comb begin
    table_d = table_q;
    if (update_valid) begin
      table_d[update_idx] = CTR_BITS'(sat_next(32'(table_q[update_idx]),
                                               update_taken, !update_taken,
                                               CTR_BITS));
    end
  end

  // Shift the resolved outcome into the global history (gshare only).
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid) begin
      if (GHR_BITS == BP_MODE_BIMODAL) begin
        ghr_d = '0;
      end else begin
        ghr_d = GW'({ghr_q, update_taken});
      end
    end
  end

  // Table and history registers; reset wins over a coincident update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CTR_RST;
      end
      ghr_q <= '0;
    end else begin
      table_q <= table_d;
      ghr_q   <= ghr_d;
    end
  end

  sat_counter #(.W(STAT_BITS)) u_stat_branches (
    .clk (clk),
    .rst (rst),
    .en  (update_valid),
    .inc (1'b1),
    .dec (1'b0),
    .q   (stat_branches)
  );

  sat_counter #(.W(STAT_BITS)) u_stat_mispreds (
    .clk (clk),
    .rst (rst),
    .en  (update_valid & update_mispred),
    .inc (1'b1),
    .dec (1'b0),
    .q   (stat_mispreds)
  );

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32 core.
- Replaces the static branch-taken input currently fed to the EX control decoder.
- Lookup is in IF: a PC is indexed into a table of saturating counters, in bimodal or gshare mode, to produce a taken prediction.
- Update comes from EX, driven by branch resolution (actual outcome and mispredict flag).
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
- PC_WIDTH, 32, width of the lookup PC.
- IDX_BITS, 6, log2 of table entries (64 entries).
- CTR_BITS, 2, saturating counter width; prediction = counter MSB; legal range 1..4.
- GHR_BITS, 0, global history length; 0 = bimodal, otherwise gshare; must be <= IDX_BITS.
- STAT_BITS, 32, width of the statistics counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- lookup_pc  in  PC_WIDTH  PC of the instruction in IF
- pred_taken  out  1  prediction for lookup_pc; combinational from the table
- pred_idx  out  IDX_BITS  table index used for this prediction; piped with the instruction to EX
- update_valid  in  1  branch resolved in EX this cycle (asserted only for OPC_BRANCH, not stalled, not flushed)
- update_idx  in  IDX_BITS  pred_idx carried down the pipe with the branch
- update_taken  in  1  actual branch outcome
- update_mispred  in  1  prediction was wrong (EX br_mispred)
- stat_branches  out  STAT_BITS  resolved branch count
- stat_mispreds  out  STAT_BITS  mispredict count

Behaviour:
- Clock and reset are decided: one clock, clk; reset is synchronous and active-high, rst. All state changes on the posedge of clk only.

Reset:
- Every table entry is set to weakly-not-taken: value 2^(CTR_BITS-1)-1, i.e. 01 for 2-bit.
- GHR is cleared to 0.
- stat_branches and stat_mispreds are cleared to 0.
- pred_taken therefore reads 0 for any PC in the cycle after reset.
- rst asserted in the same cycle as update_valid: reset wins and the update is dropped.

Index:
- Base index = lookup_pc[IDX_BITS+1:2]; bits [1:0] are ignored.
- GHR_BITS = 0: pred_idx = base.
- GHR_BITS > 0: pred_idx = base XOR zero-extended GHR.

Lookup:
- Zero latency: pred_idx and pred_taken = table[pred_idx][CTR_BITS-1] are combinational from the registered table and GHR.

Update (when update_valid = 1):
- table[update_idx] increments if update_taken, otherwise decrements.
- The counter saturates at 2^CTR_BITS-1 and at 0 (no wrap).
- GHR becomes {GHR[GHR_BITS-2:0], update_taken}. History is non-speculative: it is updated only at resolution.
- stat_branches increments by 1 and saturates at all-ones.
- stat_mispreds increments by 1 when update_mispred = 1, and saturates at all-ones.
- Updates are visible to lookups starting the following cycle.

Simultaneous update and lookup of the same index:
- The lookup returns the pre-update value; there is no bypass.
- This is intentional: it keeps the IF path short.

Other rules:
- update_valid = 0: all state is held; update_mispred is ignored.
- update_mispred = 1 with update_valid = 0 is illegal; the block ignores it.
- Stall and flush qualification of update_valid is the caller's responsibility; the block holds no per-instruction state.

Decomposition:
- Shared package/header bp_defs.vh:
  - CTR_WEAK_NT(w) initial-value macro.
  - Default parameter values.
  - Mode constant BP_MODE_BIMODAL = 0.
- Sub-module sat_counter (width parameter; inputs inc, dec, en; saturating):
  - one instance for each statistics counter;
  - table entries use the same next-value function.
- The table is a register array, not a RAM macro, because it needs a reset initialisation and an asynchronous read.

Test Plan:
- Reset then sweep 64 PCs 0x0..0xFC: pred_taken = 0 for every PC, and pred_idx = PC[7:2].
- Bimodal training: update idx 5 taken twice, then lookup PC 0x14. After the first update the entry goes 01->10 and pred_taken = 1 the next cycle. After the second it goes 10->11. Three further taken updates keep it at 11 (saturation). Three not-taken updates give 10, 01, 00, and pred_taken = 0 after the second of them.
- Same-cycle hazard: entry 3 = 01; in one cycle, lookup PC 0x0C with update idx 3 taken. pred_taken = 0 that cycle and 1 the next cycle.
- Gshare with GHR_BITS = 4: after resolved outcomes T, T, N, T, GHR = 4'b1101. Lookup PC 0x20 gives pred_idx = 8 XOR 13 = 5. rst mid-sequence returns GHR to 0 and pred_idx to 8.
- Statistics: 10 updates, 3 with update_mispred = 1, gives stat_branches = 10 and stat_mispreds = 3. With STAT_BITS = 4, 20 updates leave stat_branches stuck at 15.
- Corner parameters: CTR_BITS = 1 gives reset value 0 and toggles the prediction on each outcome change. update_mispred = 1 with update_valid = 0 changes no state.
